ser_tx_cond: RTL and testbench
==============================

SER_TX_COND -- requirements
Module: ser_tx_cond

Interface
REQ-001 Parameter SYNC_COUNT, default 4, SHALL set the number of comma bytes sent before the link is active (legal range 1..15).
REQ-002 Parameter COMMA_BYTE, default 8'hBC, SHALL set the synchronisation byte.
REQ-003 Parameter IDLE_BYTE, default 8'h7C, SHALL set the byte sent when no data is offered.
REQ-004 clk_32f  in  1  SHALL be the single bit-rate clock; all state updates on its rising edge.
REQ-005 default_values  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 enable  in  1  SHALL be the link enable; it is sampled only at byte boundaries.
REQ-007 data_in  in  8  SHALL carry the parallel byte offered for transmission.
REQ-008 valid_in  in  1  SHALL flag that data_in holds a byte.
REQ-009 ready_out  out  1  SHALL accept the offered byte; this output is combinational.
REQ-010 data_out  out  1  SHALL carry the serial bit stream, MSB first.
REQ-011 active  out  1  SHALL indicate that sync is complete and the block is in RUN.
REQ-012 idle_out  out  1  SHALL indicate that the byte now on the wire is IDLE_BYTE.
REQ-013 sync_out  out  1  SHALL indicate that the byte now on the wire is a sync COMMA_BYTE.

Function
REQ-014 Registered state SHALL be:
- shift_reg[7:0]
- bit_cnt[2:0]
- comma_cnt[3:0]
- FSM state: OFF, SYNC, RUN
REQ-015 data_out SHALL equal shift_reg[7] at all times.
REQ-016 The shift register SHALL shift left by one bit each cycle, filling the LSB with 0.
REQ-017 bit_cnt SHALL increment by 1 each cycle and wrap from 7 to 0.
REQ-018 A byte boundary is a cycle with bit_cnt==7; at a boundary, shift_reg SHALL load the next byte instead of shifting.
REQ-019 In OFF, bit_cnt SHALL be held at 7, so every OFF cycle is a boundary.
REQ-020 OFF -> SYNC SHALL occur at a boundary with enable=1:
- load COMMA_BYTE
- comma_cnt=1
- sync_out=1
REQ-021 SYNC, at a boundary with comma_cnt<SYNC_COUNT and enable=1, SHALL:
- load COMMA_BYTE
- increment comma_cnt
REQ-022 SYNC -> RUN SHALL occur at a boundary with comma_cnt==SYNC_COUNT and enable=1:
- active=1 from the next cycle
- sync_out=0
- the data/idle load rule of REQ-024 applies to this same boundary
REQ-023 ready_out SHALL be high only when all three hold:
- boundary
- enable=1
- (state==RUN, or state==SYNC with comma_cnt==SYNC_COUNT)
REQ-024 At a RUN-eligible boundary the next byte SHALL be chosen as:
- valid_in=1: load data_in, idle_out=0
- valid_in=0: load IDLE_BYTE, idle_out=1
REQ-025 A byte accepted at edge N SHALL drive its MSB on data_out in cycle N+1 and its LSB in cycle N+8 (latency 1 cycle, 8 bit times per byte).
REQ-026 At any boundary with enable=0, the block SHALL go to OFF and load 8'h00, with active, idle_out, sync_out, comma_cnt all 0.
REQ-027 enable deasserted mid-byte SHALL NOT truncate the byte on the wire; shutdown takes effect at the next boundary.
REQ-028 idle_out and sync_out SHALL be registered; they change only at boundaries and stay constant across the 8 bits of a byte.
REQ-029 Outside ready_out, valid_in SHALL be ignored; data_in is not captured and no byte is lost or duplicated.

Reset
REQ-030 While default_values=1, independent of the clock, the block SHALL hold:
- state=OFF
- shift_reg=8'h00, bit_cnt=7, comma_cnt=0
- data_out=0, active=0, idle_out=0, sync_out=0, ready_out=0
REQ-031 Reset asserted mid-byte or mid-sync SHALL abort immediately, and after release the full SYNC_COUNT comma sequence SHALL be repeated.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Reset released, enable=1, valid_in=0 -> 4x 10111100 serial, sync_out=1 for 32 cycles, then active=1, idle_out=1, 01111100 repeating.
- In RUN, offer 8'hA5 with valid_in=1 held until ready_out -> accepted at one boundary, next 8 data_out bits 1,0,1,0,0,1,0,1, idle_out=0 for that byte.
- Back-to-back 8'h01, 8'hFF, 8'h00 with valid_in held high -> one accept per 8 cycles, serial 00000001 11111111 00000000 with no gaps.
- enable dropped at bit 3 of 8'hF0 -> all 8 bits of F0 sent, then data_out=0, active=0, ready_out=0.
- default_values pulsed during the 2nd comma -> outputs 0 asynchronously; after release with enable=1, 4 full commas precede active.
- SYNC_COUNT=1 -> one comma, ready_out high at its final boundary, active 8 cycles after the first comma bit.

Source files
------------

// File: rtl/ser_tx_cond.sv
// Byte-to-serial transmitter with link conditioning: comma sync burst on enable,
// then data or idle fill bytes, shifted out MSB first at one bit per clock.
module ser_tx_cond #(
    parameter int unsigned SYNC_COUNT = 4,
    parameter logic [7:0]  COMMA_BYTE = 8'hBC,
    parameter logic [7:0]  IDLE_BYTE  = 8'h7C
) (
    input  logic       clk_32f,
    input  logic       default_values,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active,
    output logic       idle_out,
    output logic       sync_out
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned COMMA_W = 4;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(7);
    localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(SYNC_COUNT);

    logic [1:0]         state_q,     state_d;
    logic [BYTE_W-1:0]  shift_q,     shift_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [COMMA_W-1:0] comma_cnt_q, comma_cnt_d;
    logic               active_q,    active_d;
    logic               idle_q,      idle_d;
    logic               sync_q,      sync_d;

    logic boundary_c;
    logic run_ok_c;

    // Byte boundary and eligibility to load payload (RUN, or last comma of SYNC)
    always_comb begin
        boundary_c = (bit_cnt_q == BIT_LAST);
        run_ok_c   = (state_q == ST_RUN) ||
                     ((state_q == ST_SYNC) && (comma_cnt_q == COMMA_LAST));
        ready_out  = boundary_c && enable && run_ok_c;
    end

    // Next-state: shift within a byte, choose the next byte at a boundary
    always_comb begin
        state_d     = state_q;
        shift_d     = {shift_q[BYTE_W-2:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        comma_cnt_d = comma_cnt_q;
        active_d    = active_q;
        idle_d      = idle_q;
        sync_d      = sync_q;

        if (boundary_c) begin
            if (!enable) begin
                // OFF parks bit_cnt at the boundary value so every cycle re-samples enable
                state_d     = ST_OFF;
                shift_d     = '0;
                bit_cnt_d   = BIT_LAST;
                comma_cnt_d = '0;
                active_d    = 1'b0;
                idle_d      = 1'b0;
                sync_d      = 1'b0;
            end else if (run_ok_c) begin
                state_d  = ST_RUN;
                shift_d  = valid_in ? data_in : IDLE_BYTE;
                active_d = 1'b1;
                idle_d   = !valid_in;
                sync_d   = 1'b0;
            end else begin
                state_d     = ST_SYNC;
                shift_d     = COMMA_BYTE;
                comma_cnt_d = comma_cnt_q + COMMA_W'(1);
                active_d    = 1'b0;
                idle_d      = 1'b0;
                sync_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f or posedge default_values) begin
        if (default_values) begin
            state_q     <= ST_OFF;
            shift_q     <= '0;
            bit_cnt_q   <= BIT_LAST;
            comma_cnt_q <= '0;
            active_q    <= 1'b0;
            idle_q      <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            active_q    <= active_d;
            idle_q      <= idle_d;
            sync_q      <= sync_d;
        end
    end

    assign data_out = shift_q[BYTE_W-1];
    assign active   = active_q;
    assign idle_out = idle_q;
    assign sync_out = sync_q;

endmodule

// File: tb/tb_ser_tx_cond.sv
// Self-checking bench for ser_tx_cond: byte-slot table, directed corner cases,
// and randomized traffic against a byte/bit-position reference model.
module tb_ser_tx_cond;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] IDLE  = 8'h7C;
    localparam int         NSYNC = 4;

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] d;
        logic       exp_rdy;
        logic [7:0] bits;
        logic       exp_idle;
        logic       exp_sync;
        logic       exp_act;
    } slot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en = 1'b0, valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready, dout, act, idl, syn;

    logic       rst1 = 1'b1, en1 = 1'b0, valid1 = 1'b0;
    logic [7:0] din1 = 8'h00;
    logic       ready1, dout1, act1, idl1, syn1;

    int n_chk  = 0;
    int n_pass = 0;

    ser_tx_cond dut (
        .clk_32f(clk), .default_values(rst), .enable(en), .data_in(din),
        .valid_in(valid), .ready_out(ready), .data_out(dout), .active(act),
        .idle_out(idl), .sync_out(syn)
    );

    ser_tx_cond #(.SYNC_COUNT(1)) dut1 (
        .clk_32f(clk), .default_values(rst1), .enable(en1), .data_in(din1),
        .valid_in(valid1), .ready_out(ready1), .data_out(dout1), .active(act1),
        .idle_out(idl1), .sync_out(syn1)
    );

    task automatic chk(input string name, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    task automatic chk_n(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic slot_t mk(logic e, logic v, logic [7:0] d, logic r,
                                 logic [7:0] b, logic i, logic s, logic a);
        slot_t t;
        t.en = e; t.v = v; t.d = d; t.exp_rdy = r;
        t.bits = b; t.exp_idle = i; t.exp_sync = s; t.exp_act = a;
        return t;
    endfunction

    // Apply a slot at a boundary, then check the 8 bits it puts on the wire
    task automatic run_slot(input slot_t s, input string tag);
        en = s.en; valid = s.v; din = s.d;
        #1 chk($sformatf("%s ready", tag), ready, s.exp_rdy);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s bit%0d", tag, i), dout, s.bits[7-i]);
            chk($sformatf("%s idle%0d", tag, i), idl, s.exp_idle);
            chk($sformatf("%s sync%0d", tag, i), syn, s.exp_sync);
            chk($sformatf("%s act%0d", tag, i), act, s.exp_act);
            if (i < 7) begin
                valid = 1'b1; din = ~s.d;
                #1 chk($sformatf("%s midready%0d", tag, i), ready, 1'b0);
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; valid = 1'b0; din = 8'h00;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: byte on the wire plus how many of its bits have gone out
    logic [7:0] m_wire;
    int         m_pos, m_sent;
    logic       m_run, m_idle, m_sync;

    task automatic model_init();
        m_wire = 8'h00; m_pos = 7; m_sent = 0;
        m_run = 1'b0; m_idle = 1'b0; m_sync = 1'b0;
    endtask

    function automatic logic model_ready();
        return (m_pos == 7) && en && (m_run || (m_sent == NSYNC));
    endfunction

    task automatic model_step();
        logic r;
        r = model_ready();
        if (m_pos == 7) begin
            if (!en) begin
                m_wire = 8'h00; m_sent = 0; m_run = 1'b0; m_idle = 1'b0; m_sync = 1'b0;
            end else if (r) begin
                m_run = 1'b1; m_sync = 1'b0; m_idle = !valid;
                m_wire = valid ? din : IDLE; m_pos = 0;
            end else begin
                m_sent++; m_sync = 1'b1; m_wire = COMMA; m_pos = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    slot_t tbl[12];

    initial begin
        tbl[0]  = mk(1, 0, 8'h00, 0, COMMA, 0, 1, 0);
        tbl[1]  = mk(1, 0, 8'h00, 0, COMMA, 0, 1, 0);
        tbl[2]  = mk(1, 0, 8'h00, 0, COMMA, 0, 1, 0);
        tbl[3]  = mk(1, 1, 8'h33, 0, COMMA, 0, 1, 0);
        tbl[4]  = mk(1, 0, 8'h00, 1, IDLE,  1, 0, 1);
        tbl[5]  = mk(1, 1, 8'hA5, 1, 8'hA5, 0, 0, 1);
        tbl[6]  = mk(1, 1, 8'h01, 1, 8'h01, 0, 0, 1);
        tbl[7]  = mk(1, 1, 8'hFF, 1, 8'hFF, 0, 0, 1);
        tbl[8]  = mk(1, 1, 8'h00, 1, 8'h00, 0, 0, 1);
        tbl[9]  = mk(1, 0, 8'h00, 1, IDLE,  1, 0, 1);
        tbl[10] = mk(0, 1, 8'h5A, 0, 8'h00, 0, 0, 0);
        tbl[11] = mk(1, 1, 8'h55, 0, COMMA, 0, 1, 0);

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst dout", dout, 1'b0); chk("rst act", act, 1'b0);
        chk("rst idle", idl, 1'b0);  chk("rst sync", syn, 1'b0);
        en = 1'b1;
        #1 chk("rst ready", ready, 1'b0);
        en = 1'b0;
        rst = 1'b0;

        foreach (tbl[k]) run_slot(tbl[k], $sformatf("slot%0d", k));

        // enable dropped at bit 3 of F0: byte completes, then link goes OFF
        do_reset();
        for (int k = 0; k < NSYNC; k++)
            run_slot(mk(1, 0, 8'h00, 0, COMMA, 0, 1, 0), $sformatf("pre%0d", k));
        en = 1'b1; valid = 1'b1; din = 8'hF0;
        #1 chk("f0 ready", ready, 1'b1);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] f0;
            f0 = 8'hF0;
            chk($sformatf("f0 bit%0d", i), dout, f0[7-i]);
            chk($sformatf("f0 act%0d", i), act, 1'b1);
            if (i == 3) en = 1'b0;
            valid = 1'b0;
            if (i < 7) begin @(posedge clk); @(negedge clk); end
        end
        #1 chk("f0 end ready", ready, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("off dout", dout, 1'b0); chk("off act", act, 1'b0);
        chk("off idle", idl, 1'b0);  chk("off sync", syn, 1'b0);
        chk("off ready", ready, 1'b0);

        // Reset pulsed during the 2nd comma, then a full resync
        do_reset();
        en = 1'b1;
        repeat (11) begin @(posedge clk); @(negedge clk); end
        chk("c2 dout", dout, 1'b1); chk("c2 sync", syn, 1'b1);
        rst = 1'b1;
        #1;
        chk("async dout", dout, 1'b0); chk("async sync", syn, 1'b0);
        chk("async act", act, 1'b0);   chk("async idle", idl, 1'b0);
        chk("async ready", ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int cyc, nsync;
            cyc = 0; nsync = 0;
            while (cyc <= 100) begin
                @(posedge clk); @(negedge clk);
                cyc++;
                if (syn) nsync++;
                if (act) break;
            end
            chk_n("resync cycles to active", cyc, 33);
            chk_n("resync sync cycles", nsync, 32);
        end

        // SYNC_COUNT=1 instance: one comma, ready at its last boundary
        @(negedge clk);
        rst1 = 1'b0; en1 = 1'b1; valid1 = 1'b0;
        #1 chk("sc1 ready off", ready1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("sc1 bit%0d", i), dout1, COMMA[8-i]);
            chk($sformatf("sc1 sync%0d", i), syn1, 1'b1);
            chk($sformatf("sc1 act%0d", i), act1, 1'b0);
            chk($sformatf("sc1 ready%0d", i), ready1, (i == 8));
        end
        @(posedge clk); @(negedge clk);
        chk("sc1 active", act1, 1'b1); chk("sc1 idle", idl1, 1'b1);
        chk("sc1 sync end", syn1, 1'b0); chk("sc1 idle msb", dout1, IDLE[7]);

        // Randomized traffic against the reference model
        do_reset();
        model_init();
        en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (en ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 15) == 0)) en = ~en;
            valid = 1'($urandom);
            din   = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                #1;
                chk("rnd rst dout", dout, 1'b0); chk("rnd rst act", act, 1'b0);
                chk("rnd rst ready", ready, 1'b0);
                model_init();
                @(posedge clk); @(negedge clk);
                rst = 1'b0;
                continue;
            end
            #1;
            chk("rnd ready", ready, model_ready());
            chk("rnd dout", dout, m_wire[3'(7 - m_pos)]);
            chk("rnd act", act, m_run);
            chk("rnd idle", idl, m_idle);
            chk("rnd sync", syn, m_sync);
            model_step();
            @(posedge clk); @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
